// File: rtl/fp_multicycle_issue.sv
// FP sub-unit issue stage: takes one op from EX, starts a multi-cycle FP unit,
// waits for its result pulse and holds the tagged result for writeback.
// Stalls EX while an op is in flight or a result is waiting.

package riscv_pkg;
  typedef enum logic [4:0] {
    OP_NOP    = 5'd0,
    OP_FSGNJ  = 5'd1,
    OP_FSGNJN = 5'd2,
    OP_FSGNJX = 5'd3,
    OP_FMIN   = 5'd4,
    OP_FMAX   = 5'd5,
    OP_FDIV   = 5'd6,
    OP_FSQRT  = 5'd7
  } instr_op_e;
endpackage

module fp_multicycle_issue #(
  parameter int FLEN           = 32,
  parameter int RD_W           = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  riscv_pkg::instr_op_e i_req_op,
  input  logic [FLEN-1:0]      i_req_a,
  input  logic [FLEN-1:0]      i_req_b,
  input  logic [RD_W-1:0]      i_req_rd,
  output logic                 o_unit_valid,
  output riscv_pkg::instr_op_e o_unit_op,
  output logic [FLEN-1:0]      o_unit_a,
  output logic [FLEN-1:0]      o_unit_b,
  input  logic                 i_unit_valid,
  input  logic [FLEN-1:0]      i_unit_result,
  output logic                 o_wb_valid,
  input  logic                 i_wb_ready,
  output logic [RD_W-1:0]      o_wb_rd,
  output logic [FLEN-1:0]      o_wb_data,
  input  logic                 i_flush,
  output logic                 o_stall,
  output logic                 o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN, S_HOLD} state_e;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             busy;
  logic             expire;

  // A new op may enter from IDLE, or from HOLD in the same cycle the held
  // result retires; a flush blocks any accept that cycle.
  assign o_req_ready = !i_flush && ((state == S_IDLE) || ((state == S_HOLD) && i_wb_ready));
  assign accept      = i_req_valid && o_req_ready;

  // Start stays high through the result cycle so the unit always completes its
  // handshake, even when the op is being drained after a flush.
  assign busy         = (state == S_WAIT) || (state == S_DRAIN);
  assign o_unit_valid = busy;
  assign o_wb_valid   = (state == S_HOLD);
  assign o_stall      = (state != S_IDLE);

  // A result arriving on the last allowed cycle beats the timeout.
  assign expire = busy && !i_unit_valid && (cnt == CNT_LAST);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_unit_valid)  state_nxt = i_flush ? S_IDLE : S_HOLD;
        else if (expire)   state_nxt = S_IDLE;
        else if (i_flush)  state_nxt = S_DRAIN;
      end
      S_DRAIN: if (i_unit_valid || expire) state_nxt = S_IDLE;
      S_HOLD: begin
        if (i_flush)         state_nxt = S_IDLE;
        else if (i_wb_ready) state_nxt = accept ? S_WAIT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Op capture, wait counter, result latch and sticky timeout flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_unit_op <= riscv_pkg::OP_NOP;
      o_unit_a  <= '0;
      o_unit_b  <= '0;
      o_wb_rd   <= '0;
      o_wb_data <= '0;
      cnt       <= '0;
      o_timeout <= 1'b0;
    end else begin
      if (accept) begin
        o_unit_op <= i_req_op;
        o_unit_a  <= i_req_a;
        o_unit_b  <= i_req_b;
        o_wb_rd   <= i_req_rd;
        cnt       <= '0;
      end else if (busy && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
      if ((state == S_WAIT) && i_unit_valid && !i_flush)
        o_wb_data <= i_unit_result;
      if (expire)
        o_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_multicycle_issue.sv
// Directed bench for fp_multicycle_issue: the sub-unit is played by hand,
// each scenario drives its own vectors and checks against constants.

module tb_fp_multicycle_issue;
  import riscv_pkg::*;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_req_valid;
  logic            o_req_ready;
  instr_op_e       i_req_op;
  logic [31:0]     i_req_a, i_req_b;
  logic [4:0]      i_req_rd;
  logic            o_unit_valid;
  instr_op_e       o_unit_op;
  logic [31:0]     o_unit_a, o_unit_b;
  logic            i_unit_valid;
  logic [31:0]     i_unit_result;
  logic            o_wb_valid;
  logic            i_wb_ready;
  logic [4:0]      o_wb_rd;
  logic [31:0]     o_wb_data;
  logic            i_flush;
  logic            o_stall;
  logic            o_timeout;

  int vec = 0;
  int err = 0;

  fp_multicycle_issue #(.FLEN(32), .RD_W(5), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_op(i_req_op),
    .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_rd(i_req_rd),
    .o_unit_valid(o_unit_valid), .o_unit_op(o_unit_op), .o_unit_a(o_unit_a), .o_unit_b(o_unit_b),
    .i_unit_valid(i_unit_valid), .i_unit_result(i_unit_result),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .i_flush(i_flush), .o_stall(o_stall), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // Inputs change 1 ns after the rising edge; checks run 1 ns later.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_req(input instr_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_a     = a;
    i_req_b     = b;
    i_req_rd    = rd;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_req_valid = 1'b0; i_req_op = OP_NOP; i_req_a = '0; i_req_b = '0;
    i_req_rd = '0; i_unit_valid = 1'b0; i_unit_result = '0; i_wb_ready = 1'b0; i_flush = 1'b0;
    tick(); tick();
    i_rst = 1'b0; #1;
    vec++; if ({o_req_ready, o_unit_valid, o_wb_valid, o_stall, o_timeout} !== 5'b10000) begin
      err++; $display("FAIL reset_ctrl: got %b want 10000",
                      {o_req_ready, o_unit_valid, o_wb_valid, o_stall, o_timeout});
    end
    vec++; if ({o_unit_op, o_unit_a, o_unit_b, o_wb_rd, o_wb_data} !== 106'd0) begin
      err++; $display("FAIL reset_regs: got op=%0d a=%h b=%h rd=%0d data=%h want all 0",
                      o_unit_op, o_unit_a, o_unit_b, o_wb_rd, o_wb_data);
    end
  endtask

  // FSGNJN 1.0, +0 -> -1.0; result visible 3 cycles after accept.
  task automatic test_basic();
    tick();
    drive_req(OP_FSGNJN, 32'h3F800000, 32'h00000000, 5'd3); i_wb_ready = 1'b1; #1;
    vec++; if (o_req_ready !== 1'b1) begin
      err++; $display("FAIL basic_ready: got %b want 1", o_req_ready);
    end
    tick(); i_req_valid = 1'b0; #1;
    vec++; if ({o_unit_valid, o_stall, o_wb_valid, o_req_ready} !== 4'b1100) begin
      err++; $display("FAIL basic_wait: got %b want 1100",
                      {o_unit_valid, o_stall, o_wb_valid, o_req_ready});
    end
    vec++; if (o_unit_op !== OP_FSGNJN || o_unit_a !== 32'h3F800000 || o_unit_b !== 32'h0) begin
      err++; $display("FAIL basic_operands: got op=%0d a=%h b=%h want op=2 a=3f800000 b=0",
                      o_unit_op, o_unit_a, o_unit_b);
    end
    tick(); i_unit_valid = 1'b1; i_unit_result = 32'hBF800000; #1;
    vec++; if ({o_unit_valid, o_wb_valid} !== 2'b10) begin
      err++; $display("FAIL basic_result_cycle: got %b want 10", {o_unit_valid, o_wb_valid});
    end
    tick(); i_unit_valid = 1'b0; #1;
    vec++; if ({o_wb_valid, o_unit_valid} !== 2'b10 || o_wb_data !== 32'hBF800000 || o_wb_rd !== 5'd3) begin
      err++; $display("FAIL basic_hold: got v=%b uv=%b data=%h rd=%0d want v=1 uv=0 data=bf800000 rd=3",
                      o_wb_valid, o_unit_valid, o_wb_data, o_wb_rd);
    end
    tick(); #1;
    vec++; if ({o_stall, o_wb_valid, o_req_ready} !== 3'b001) begin
      err++; $display("FAIL basic_idle: got %b want 001", {o_stall, o_wb_valid, o_req_ready});
    end
  endtask

  // Second op accepted in the cycle the first result retires.
  task automatic test_back_to_back();
    drive_req(OP_FSGNJ, 32'h40000000, 32'h80000000, 5'd5); i_wb_ready = 1'b1;
    tick(); i_req_valid = 1'b0;
    tick(); i_unit_valid = 1'b1; i_unit_result = 32'hC0000000;
    tick(); i_unit_valid = 1'b0;
    drive_req(OP_FSGNJX, 32'hC0400000, 32'h80000000, 5'd7); #1;
    vec++; if (o_req_ready !== 1'b1 || o_wb_valid !== 1'b1 || o_wb_data !== 32'hC0000000 || o_wb_rd !== 5'd5) begin
      err++; $display("FAIL b2b_first: got rdy=%b v=%b data=%h rd=%0d want rdy=1 v=1 data=c0000000 rd=5",
                      o_req_ready, o_wb_valid, o_wb_data, o_wb_rd);
    end
    tick(); i_req_valid = 1'b0; #1;
    vec++; if ({o_unit_valid, o_wb_valid, o_stall} !== 3'b101 || o_unit_a !== 32'hC0400000) begin
      err++; $display("FAIL b2b_no_bubble: got uv/v/st=%b a=%h want 101 a=c0400000",
                      {o_unit_valid, o_wb_valid, o_stall}, o_unit_a);
    end
    tick(); i_unit_valid = 1'b1; i_unit_result = 32'h40400000;
    tick(); i_unit_valid = 1'b0; #1;
    vec++; if (o_wb_valid !== 1'b1 || o_wb_data !== 32'h40400000 || o_wb_rd !== 5'd7) begin
      err++; $display("FAIL b2b_second: got v=%b data=%h rd=%0d want v=1 data=40400000 rd=7",
                      o_wb_valid, o_wb_data, o_wb_rd);
    end
    tick(); #1;
    vec++; if (o_stall !== 1'b0) begin
      err++; $display("FAIL b2b_idle: got stall=%b want 0", o_stall);
    end
  endtask

  // Writeback back-pressure for 5 cycles, with a stray unit pulse in HOLD.
  task automatic test_wb_stall();
    drive_req(OP_FMIN, 32'h00000001, 32'h00000002, 5'd9); i_wb_ready = 1'b0;
    tick(); i_req_valid = 1'b0;
    tick(); i_unit_valid = 1'b1; i_unit_result = 32'h12345678;
    tick(); i_unit_valid = 1'b0;
    drive_req(OP_FMAX, 32'h11111111, 32'h22222222, 5'd1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin i_unit_valid = 1'b1; i_unit_result = 32'hDEADBEEF; end
      else i_unit_valid = 1'b0;
      #1;
      vec++; if ({o_wb_valid, o_req_ready, o_stall} !== 3'b101 || o_wb_data !== 32'h12345678 || o_wb_rd !== 5'd9) begin
        err++; $display("FAIL wb_stall_%0d: got v/rdy/st=%b data=%h rd=%0d want 101 data=12345678 rd=9",
                        k, {o_wb_valid, o_req_ready, o_stall}, o_wb_data, o_wb_rd);
      end
      tick();
    end
    i_unit_valid = 1'b0; i_req_valid = 1'b0; i_wb_ready = 1'b1;
    tick(); #1;
    vec++; if ({o_stall, o_wb_valid} !== 2'b00) begin
      err++; $display("FAIL wb_stall_release: got %b want 00", {o_stall, o_wb_valid});
    end
  endtask

  // Flush while the unit is still working: start held, result discarded.
  task automatic test_flush_drain();
    drive_req(OP_FDIV, 32'h40400000, 32'h40000000, 5'd4); i_wb_ready = 1'b1;
    tick(); i_req_valid = 1'b0; i_flush = 1'b1; #1;
    vec++; if (o_req_ready !== 1'b0) begin
      err++; $display("FAIL drain_ready: got %b want 0", o_req_ready);
    end
    tick(); i_flush = 1'b0; #1;
    vec++; if ({o_unit_valid, o_stall, o_wb_valid} !== 3'b110) begin
      err++; $display("FAIL drain_hold_start: got %b want 110", {o_unit_valid, o_stall, o_wb_valid});
    end
    i_unit_valid = 1'b1; i_unit_result = 32'h3FC00000;
    tick(); i_unit_valid = 1'b0; #1;
    vec++; if ({o_unit_valid, o_stall, o_wb_valid} !== 3'b000) begin
      err++; $display("FAIL drain_done: got %b want 000", {o_unit_valid, o_stall, o_wb_valid});
    end
  endtask

  // Flush in HOLD beats writeback ready and blocks a same-cycle accept.
  task automatic test_flush_hold();
    drive_req(OP_FMAX, 32'h3F800000, 32'h40000000, 5'd6); i_wb_ready = 1'b1;
    tick(); i_req_valid = 1'b0;
    tick(); i_unit_valid = 1'b1; i_unit_result = 32'h40000000;
    tick(); i_unit_valid = 1'b0; i_flush = 1'b1;
    drive_req(OP_FMIN, 32'h1, 32'h2, 5'd2); #1;
    vec++; if ({o_wb_valid, o_req_ready} !== 2'b10) begin
      err++; $display("FAIL flush_hold_ready: got %b want 10", {o_wb_valid, o_req_ready});
    end
    tick(); i_flush = 1'b0; i_req_valid = 1'b0; #1;
    vec++; if ({o_stall, o_wb_valid, o_unit_valid} !== 3'b000) begin
      err++; $display("FAIL flush_hold_drop: got %b want 000", {o_stall, o_wb_valid, o_unit_valid});
    end
  endtask

  // Result on the last allowed WAIT cycle wins over the timeout.
  task automatic test_timeout_edge();
    drive_req(OP_FSQRT, 32'h41800000, 32'h0, 5'd10); i_wb_ready = 1'b1;
    tick(); i_req_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    i_unit_valid = 1'b1; i_unit_result = 32'h40800000;
    tick(); i_unit_valid = 1'b0; #1;
    vec++; if (o_wb_valid !== 1'b1 || o_timeout !== 1'b0 || o_wb_data !== 32'h40800000) begin
      err++; $display("FAIL timeout_edge: got v=%b to=%b data=%h want v=1 to=0 data=40800000",
                      o_wb_valid, o_timeout, o_wb_data);
    end
    tick();
  endtask

  // Unit never answers: abandoned after 8 WAIT cycles, then normal service.
  task automatic test_timeout();
    drive_req(OP_FDIV, 32'h3F800000, 32'h0, 5'd11); i_wb_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(); i_req_valid = 1'b0; #1;
      vec++; if ({o_unit_valid, o_stall, o_timeout} !== 3'b110) begin
        err++; $display("FAIL timeout_wait_%0d: got %b want 110", k, {o_unit_valid, o_stall, o_timeout});
      end
    end
    tick(); #1;
    vec++; if ({o_timeout, o_stall, o_unit_valid, o_wb_valid, o_req_ready} !== 5'b10001) begin
      err++; $display("FAIL timeout_fire: got %b want 10001",
                      {o_timeout, o_stall, o_unit_valid, o_wb_valid, o_req_ready});
    end
    drive_req(OP_FSGNJN, 32'hBF800000, 32'h80000000, 5'd12);
    tick(); i_req_valid = 1'b0;
    tick(); i_unit_valid = 1'b1; i_unit_result = 32'h3F800000;
    tick(); i_unit_valid = 1'b0; #1;
    vec++; if (o_wb_valid !== 1'b1 || o_wb_data !== 32'h3F800000 || o_wb_rd !== 5'd12 || o_timeout !== 1'b1) begin
      err++; $display("FAIL timeout_recover: got v=%b data=%h rd=%0d to=%b want v=1 data=3f800000 rd=12 to=1",
                      o_wb_valid, o_wb_data, o_wb_rd, o_timeout);
    end
    tick();
  endtask

  // Reset in WAIT: everything cleared next edge, a late result is ignored.
  task automatic test_reset_mid();
    drive_req(OP_FSGNJ, 32'h12345678, 32'h87654321, 5'd13); i_wb_ready = 1'b1;
    tick(); i_req_valid = 1'b0; i_rst = 1'b1;
    tick(); i_rst = 1'b0; #1;
    vec++; if ({o_req_ready, o_unit_valid, o_wb_valid, o_stall, o_timeout} !== 5'b10000) begin
      err++; $display("FAIL rst_mid_ctrl: got %b want 10000",
                      {o_req_ready, o_unit_valid, o_wb_valid, o_stall, o_timeout});
    end
    vec++; if ({o_unit_a, o_wb_data, o_wb_rd} !== 69'd0) begin
      err++; $display("FAIL rst_mid_regs: got a=%h data=%h rd=%0d want 0", o_unit_a, o_wb_data, o_wb_rd);
    end
    i_unit_valid = 1'b1; i_unit_result = 32'hCAFEF00D;
    tick(); i_unit_valid = 1'b0; #1;
    vec++; if ({o_stall, o_wb_valid} !== 2'b00 || o_wb_data !== 32'h0) begin
      err++; $display("FAIL rst_mid_stray: got st/v=%b data=%h want 00 data=0", {o_stall, o_wb_valid}, o_wb_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_wb_stall();
    test_flush_drain();
    test_flush_hold();
    test_timeout_edge();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
